// File: rtl/zbin_pkg.sv
// Shared definitions for the z-bin jet-finding blocks.
package zbin_pkg;

   localparam int NBINS  = 8;
   localparam int ZBIN_W = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_e;

   // Unsigned saturating add for operands up to 64 bits; w is the result width.
   function automatic logic [63:0] sat_add_u(input logic [63:0] a,
                                             input logic [63:0] b,
                                             input int unsigned w);
      logic [64:0] s;
      logic [63:0] max;
      s   = {1'b0, a} + {1'b0, b};
      max = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      return (s > {1'b0, max}) ? max : s[63:0];
   endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational saturating adder: sum = min(a + zero-extended b, 2^WIDTH-1).
module sat_add #(
   parameter int WIDTH    = 32,
   parameter int PT_WIDTH = 16
) (
   input  logic [WIDTH-1:0]    a,
   input  logic [PT_WIDTH-1:0] b,
   output logic [WIDTH-1:0]    sum
);

   logic [WIDTH:0] full;

   assign full = {1'b0, a} + (WIDTH + 1)'(b);
   assign sum  = full[WIDTH] ? '1 : full[WIDTH-1:0];

endmodule

// File: rtl/zbin_pt_accumulator.sv
// Per-event z-bin track-pT histogrammer with a held, double-buffered result.
module zbin_pt_accumulator
   import zbin_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int PT_WIDTH  = 16,
   parameter int CNT_WIDTH = 12
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic                 in_first,
   input  logic                 in_last,
   input  logic [ZBIN_W-1:0]    in_zbin,
   input  logic [PT_WIDTH-1:0]  in_pt,
   output logic [WIDTH-1:0]     out0,
   output logic [WIDTH-1:0]     out1,
   output logic [WIDTH-1:0]     out2,
   output logic [WIDTH-1:0]     out3,
   output logic [WIDTH-1:0]     out4,
   output logic [WIDTH-1:0]     out5,
   output logic [WIDTH-1:0]     out6,
   output logic [WIDTH-1:0]     out7,
   output logic [CNT_WIDTH-1:0] out_ntrk,
   output logic                 out_valid,
   output logic                 err_orphan,
   output logic                 err_trunc
);

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     acc_q [NBINS];
   logic [WIDTH-1:0]     acc_d [NBINS];
   logic [WIDTH-1:0]     out_q [NBINS];
   logic [WIDTH-1:0]     out_d [NBINS];
   logic [WIDTH-1:0]     sum   [NBINS];
   logic [CNT_WIDTH-1:0] ntrk_q, ntrk_d;
   logic [CNT_WIDTH-1:0] out_ntrk_q, out_ntrk_d;
   logic                 out_valid_q, out_valid_d;
   logic                 err_orphan_q, err_orphan_d;
   logic                 err_trunc_q, err_trunc_d;
   logic                 publish;

   // One saturating adder per bin; only the addressed bin's result is used.
   for (genvar k = 0; k < NBINS; k++) begin : g_add
      sat_add #(.WIDTH(WIDTH), .PT_WIDTH(PT_WIDTH)) u_sat_add (
         .a   (acc_q[k]),
         .b   (in_pt),
         .sum (sum[k])
      );
   end

   // Next-state, working-set update and publish decision for one beat.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      state_d      = state_q;
      acc_d        = acc_q;
      ntrk_d       = ntrk_q;
      out_d        = out_q;
      out_ntrk_d   = out_ntrk_q;
      out_valid_d  = 1'b0;
      err_orphan_d = 1'b0;
      err_trunc_d  = 1'b0;
      publish      = 1'b0;

      if (in_valid) begin
         if (in_first) begin
            // A new event always restarts the working set, even mid-event.
            err_trunc_d = (state_q == ACCUM);
            for (int k = 0; k < NBINS; k++) acc_d[k] = '0;
            acc_d[in_zbin] = WIDTH'(in_pt);
            ntrk_d         = CNT_WIDTH'(1);
            publish        = in_last;
            state_d        = in_last ? IDLE : ACCUM;
         end else if (state_q == IDLE) begin
            err_orphan_d = 1'b1;
         end else begin
            acc_d[in_zbin] = sum[in_zbin];
            ntrk_d         = (ntrk_q == '1) ? ntrk_q : ntrk_q + CNT_WIDTH'(1);
            publish        = in_last;
            state_d        = in_last ? IDLE : ACCUM;
         end
      end

      // The published set includes the in_last beat itself.
      if (publish) begin
         out_d       = acc_d;
         out_ntrk_d  = ntrk_d;
         out_valid_d = 1'b1;
      end
   end

   // State, working and published register banks with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset) begin
         // NOTE: the bin banks are small register files, so resetting them is cheap and
         // guarantees untouched bins publish 0 after reset.
         state_q      <= IDLE;
         for (int k = 0; k < NBINS; k++) begin
            acc_q[k] <= '0;
            out_q[k] <= '0;
         end
         ntrk_q       <= '0;
         out_ntrk_q   <= '0;
         out_valid_q  <= 1'b0;
         err_orphan_q <= 1'b0;
         err_trunc_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         out_q        <= out_d;
         ntrk_q       <= ntrk_d;
         out_ntrk_q   <= out_ntrk_d;
         out_valid_q  <= out_valid_d;
         err_orphan_q <= err_orphan_d;
         err_trunc_q  <= err_trunc_d;
      end
   end

   assign out0       = out_q[0];
   assign out1       = out_q[1];
   assign out2       = out_q[2];
   assign out3       = out_q[3];
   assign out4       = out_q[4];
   assign out5       = out_q[5];
   assign out6       = out_q[6];
   assign out7       = out_q[7];
   assign out_ntrk   = out_ntrk_q;
   assign out_valid  = out_valid_q;
   assign err_orphan = err_orphan_q;
   assign err_trunc  = err_trunc_q;

endmodule

// File: tb/tb_zbin_pt_accumulator.sv
// Self-checking bench: directed table, hand-written corner sequences, and a
// randomized run against an event-level reference model. A 16-bit-wide second
// instance shares the stimulus to exercise bin saturation.
module tb_zbin_pt_accumulator;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_first, in_last;
   logic [2:0]  in_zbin;
   logic [15:0] in_pt;

   logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7;
   logic [11:0] a_ntrk;
   logic        a_valid, a_orph, a_trunc;
   logic [15:0] s0, s1, s2, s3, s4, s5, s6, s7;
   logic [11:0] s_ntrk;
   logic        s_valid, s_orph, s_trunc;

   logic [31:0] o32 [8];
   logic [15:0] o16 [8];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   zbin_pt_accumulator dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_first(in_first),
      .in_last(in_last), .in_zbin(in_zbin), .in_pt(in_pt),
      .out0(a0), .out1(a1), .out2(a2), .out3(a3),
      .out4(a4), .out5(a5), .out6(a6), .out7(a7),
      .out_ntrk(a_ntrk), .out_valid(a_valid),
      .err_orphan(a_orph), .err_trunc(a_trunc)
   );

   zbin_pt_accumulator #(.WIDTH(16), .PT_WIDTH(16), .CNT_WIDTH(12)) dut_s (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_first(in_first),
      .in_last(in_last), .in_zbin(in_zbin), .in_pt(in_pt),
      .out0(s0), .out1(s1), .out2(s2), .out3(s3),
      .out4(s4), .out5(s5), .out6(s6), .out7(s7),
      .out_ntrk(s_ntrk), .out_valid(s_valid),
      .err_orphan(s_orph), .err_trunc(s_trunc)
   );

   assign o32[0] = a0; assign o32[1] = a1; assign o32[2] = a2; assign o32[3] = a3;
   assign o32[4] = a4; assign o32[5] = a5; assign o32[6] = a6; assign o32[7] = a7;
   assign o16[0] = s0; assign o16[1] = s1; assign o16[2] = s2; assign o16[3] = s3;
   assign o16[4] = s4; assign o16[5] = s5; assign o16[6] = s6; assign o16[7] = s7;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive one beat half a cycle ahead of the edge; sample 1 ns after it.
   task automatic step(input bit v, input bit f, input bit l, input int z, input int pt);
      @(negedge clk);
      in_valid = v;
      in_first = f;
      in_last  = l;
      in_zbin  = 3'(z);
      in_pt    = 16'(pt);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic longint all_sum();
      longint s = 0;
      for (int k = 0; k < 8; k++) s += o32[k];
      return s;
   endfunction

   // ---------------- reference model (event level) ----------------
   bit     m_in_evt;
   int     m_z[$];
   longint m_pt[$];
   longint m_out32 [8];
   longint m_out16 [8];
   longint m_ntrk;
   bit     m_valid, m_orph, m_trunc;

   function automatic void model_reset();
      m_in_evt = 0;
      m_z.delete();
      m_pt.delete();
      for (int k = 0; k < 8; k++) begin
         m_out32[k] = 0;
         m_out16[k] = 0;
      end
      m_ntrk  = 0;
      m_valid = 0;
      m_orph  = 0;
      m_trunc = 0;
   endfunction

   // Published bin = min(total pT of the event in that bin, full scale).
   function automatic void model_publish();
      for (int k = 0; k < 8; k++) begin
         longint tot = 0;
         foreach (m_z[i]) if (m_z[i] == k) tot += m_pt[i];
         m_out32[k] = (tot > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : tot;
         m_out16[k] = (tot > 64'hFFFF) ? 64'hFFFF : tot;
      end
      m_ntrk  = (m_z.size() > 4095) ? 4095 : m_z.size();
      m_valid = 1;
   endfunction

   function automatic void model_beat(input bit v, input bit f, input bit l,
                                      input int z, input int pt);
      m_valid = 0;
      m_orph  = 0;
      m_trunc = 0;
      if (!v) return;
      if (f) begin
         m_trunc = m_in_evt;
         m_z.delete();
         m_pt.delete();
         m_z.push_back(z);
         m_pt.push_back(pt);
         m_in_evt = !l;
         if (l) model_publish();
      end else if (!m_in_evt) begin
         m_orph = 1;
      end else begin
         m_z.push_back(z);
         m_pt.push_back(pt);
         if (l) begin
            m_in_evt = 0;
            model_publish();
         end
      end
   endfunction

   // ---------------- directed table ----------------
   typedef struct {
      bit     v, f, l;
      int     z, pt;
      bit     ev, eo, et;
      int     ia;
      longint va;
      int     ib;
      longint vb;
      longint nt;
      longint sm;
   } vec_t;

   vec_t tbl [13];

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
      in_zbin  = '0;
      in_pt    = '0;

      //         v  f  l  z  pt    ev eo et ia va   ib vb   nt sm
      tbl[0]  = '{0, 0, 0, 0, 0,    0, 0, 0, 0, 0,   0, 0,   0, 0};
      tbl[1]  = '{1, 1, 1, 5, 100,  1, 0, 0, 5, 100, 5, 100, 1, 100};
      tbl[2]  = '{1, 1, 0, 2, 10,   0, 0, 0, 5, 100, 5, 100, 1, 100};
      tbl[3]  = '{1, 0, 0, 2, 20,   0, 0, 0, 5, 100, 5, 100, 1, 100};
      tbl[4]  = '{1, 0, 0, 7, 5,    0, 0, 0, 5, 100, 5, 100, 1, 100};
      tbl[5]  = '{1, 0, 1, 2, 1,    1, 0, 0, 2, 31,  7, 5,   4, 36};
      tbl[6]  = '{1, 0, 0, 3, 50,   0, 1, 0, 2, 31,  7, 5,   4, 36};
      tbl[7]  = '{1, 1, 0, 4, 77,   0, 0, 0, 2, 31,  7, 5,   4, 36};
      tbl[8]  = '{1, 1, 1, 6, 9,    1, 0, 1, 6, 9,   6, 9,   1, 9};
      tbl[9]  = '{1, 1, 0, 0, 3,    0, 0, 0, 6, 9,   6, 9,   1, 9};
      tbl[10] = '{1, 0, 1, 1, 4,    1, 0, 0, 0, 3,   1, 4,   2, 7};
      tbl[11] = '{1, 1, 0, 3, 8,    0, 0, 0, 0, 3,   1, 4,   2, 7};
      tbl[12] = '{1, 0, 1, 3, 8,    1, 0, 0, 3, 16,  3, 16,  2, 16};

      // Reset state.
      @(posedge clk);
      #1;
      do_reset();
      @(posedge clk);
      #1;
      check("reset_sum", all_sum(), 0);
      check("reset_ntrk", a_ntrk, 0);
      check("reset_valid", a_valid, 0);
      check("reset_orphan", a_orph, 0);
      check("reset_trunc", a_trunc, 0);

      for (int i = 0; i < 13; i++) begin
         step(tbl[i].v, tbl[i].f, tbl[i].l, tbl[i].z, tbl[i].pt);
         check($sformatf("tbl%0d_valid", i), a_valid, tbl[i].ev);
         check($sformatf("tbl%0d_orphan", i), a_orph, tbl[i].eo);
         check($sformatf("tbl%0d_trunc", i), a_trunc, tbl[i].et);
         check($sformatf("tbl%0d_bin_a", i), o32[tbl[i].ia], tbl[i].va);
         check($sformatf("tbl%0d_bin_b", i), o32[tbl[i].ib], tbl[i].vb);
         check($sformatf("tbl%0d_ntrk", i), a_ntrk, tbl[i].nt);
         check($sformatf("tbl%0d_sum", i), all_sum(), tbl[i].sm);
         if (i == 5) begin
            // The 4-track result must hold through idle cycles.
            for (int c = 0; c < 10; c++) begin
               step(0, 1, 1, 0, 0);
               check("hold_out2", a2, 31);
               check("hold_out7", a7, 5);
               check("hold_ntrk", a_ntrk, 4);
               check("hold_valid", a_valid, 0);
            end
         end
      end

      // Saturation in the 16-bit instance; the 32-bit one must not saturate.
      do_reset();
      step(1, 1, 0, 0, 16'hFFFF);
      step(1, 0, 0, 0, 16'hFFFF);
      step(1, 0, 1, 0, 16'hFFFF);
      check("sat16_valid", s_valid, 1);
      check("sat16_out0", s0, 16'hFFFF);
      check("sat16_ntrk", s_ntrk, 3);
      check("sat32_out0", a0, 32'h0002_FFFD);

      // Reset mid-event clears the published set and drops the working set.
      step(1, 1, 0, 4, 200);
      step(1, 0, 0, 4, 300);
      do_reset();
      #1;
      check("rst_mid_sum", all_sum(), 0);
      check("rst_mid_sat_out0", s0, 0);
      check("rst_mid_ntrk", a_ntrk, 0);
      check("rst_mid_valid", a_valid, 0);
      step(1, 0, 1, 4, 10);
      check("rst_after_orphan", a_orph, 1);
      check("rst_after_novalid", a_valid, 0);
      check("rst_after_sum", all_sum(), 0);
      step(1, 1, 0, 1, 11);
      check("rst_next_novalid", a_valid, 0);
      step(1, 0, 1, 1, 12);
      check("rst_next_valid", a_valid, 1);
      check("rst_next_out1", a1, 23);
      check("rst_next_ntrk", a_ntrk, 2);

      // Randomized run against the event-level model.
      do_reset();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         bit v, f, l;
         int z, pt;
         if ($urandom_range(0, 399) == 0) begin
            do_reset();
            model_reset();
         end
         v  = ($urandom_range(0, 9) < 8);
         f  = ($urandom_range(0, 9) < 2);
         l  = ($urandom_range(0, 9) < 2);
         z  = $urandom_range(0, 7);
         pt = (c % 2 == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 300);
         step(v, f, l, z, pt);
         model_beat(v, f, l, z, pt);
         check("rnd_valid", a_valid, m_valid);
         check("rnd_orphan", a_orph, m_orph);
         check("rnd_trunc", a_trunc, m_trunc);
         check("rnd_ntrk", a_ntrk, m_ntrk);
         check("rnd_s_valid", s_valid, m_valid);
         check("rnd_s_ntrk", s_ntrk, m_ntrk);
         for (int k = 0; k < 8; k++) begin
            check($sformatf("rnd_out%0d", k), o32[k], m_out32[k]);
            check($sformatf("rnd_s_out%0d", k), o16[k], m_out16[k]);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
